ram_rw: RTL and testbench

RAM_RW -- requirements
Module: ram_rw

---
 rtl/ram_rw_pkg.sv | 24 ++
 rtl/ram_rw.sv | 74 +++++++
 tb/tb_ram_rw.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ram_rw_pkg.sv
// Shared definitions for the SPI host RAM access block: command opcodes,
// the byte-lane count, and the port-B select bundle.
package ram_rw_pkg;

  typedef enum logic [7:0] {
    CPU_RST = 8'h2A,
    CPU_RUN = 8'h2B,
    IRAM_WR = 8'h2C,
    IRAM_RD = 8'h2D,
    DRAM_WR = 8'h2E,
    DRAM_RD = 8'h2F
  } cmd_e;

  localparam int unsigned NUM_LANES = 4;

  // At most one member is high; all low means no host access is active.
  typedef struct packed {
    logic iram_rd;
    logic iram_wr;
    logic dram_rd;
    logic dram_wr;
  } sel_t;

endpackage

// File: rtl/ram_rw.sv
// Decodes SPI command/data bytes into CPU reset control, one-hot RAM port-B
// selects, an auto-incrementing byte address and per-lane write enables.
module ram_rw
  import ram_rw_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 dc_i,
  input  logic                 spi_byte_vld_i,
  input  logic [7:0]           spi_byte_data_i,
  output logic                 cpu_rst_n_o,
  output logic                 iram_rd_sel_o,
  output logic                 iram_wr_sel_o,
  output logic                 dram_rd_sel_o,
  output logic                 dram_wr_sel_o,
  output logic [XLEN-1:0]      ram_rw_addr_o,
  output logic [NUM_LANES-1:0] ram_wr_byte_en_o
);

  sel_t            sel_q, sel_d;
  logic            cpu_rst_n_q, cpu_rst_n_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            wr_hit;

  always_comb begin
    sel_d       = sel_q;
    cpu_rst_n_d = cpu_rst_n_q;
    addr_d      = addr_q;
    if (spi_byte_vld_i) begin
      if (!dc_i) begin
        sel_d  = '0;
        addr_d = '0;
        case (spi_byte_data_i)
          CPU_RST: cpu_rst_n_d = 1'b0;
          CPU_RUN: cpu_rst_n_d = 1'b1;
          IRAM_WR: begin sel_d.iram_wr = 1'b1; cpu_rst_n_d = 1'b0; end
          IRAM_RD: begin sel_d.iram_rd = 1'b1; cpu_rst_n_d = 1'b0; end
          DRAM_WR: begin sel_d.dram_wr = 1'b1; cpu_rst_n_d = 1'b0; end
          DRAM_RD: begin sel_d.dram_rd = 1'b1; cpu_rst_n_d = 1'b0; end
          default: ;
        endcase
      end else if (|sel_q) begin
        // Natural overflow gives the modulo 2^XLEN wrap.
        addr_d = addr_q + XLEN'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sel_q       <= '0;
      cpu_rst_n_q <= 1'b0;
      addr_q      <= '0;
    end else begin
      sel_q       <= sel_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      addr_q      <= addr_d;
    end
  end

  // Uses the pre-increment address so the lane matches the byte being written.
  assign wr_hit           = (sel_q.iram_wr | sel_q.dram_wr) & spi_byte_vld_i & dc_i;
  assign ram_wr_byte_en_o = wr_hit ? (NUM_LANES'(1) << addr_q[1:0]) : '0;

  assign cpu_rst_n_o   = cpu_rst_n_q;
  assign iram_rd_sel_o = sel_q.iram_rd;
  assign iram_wr_sel_o = sel_q.iram_wr;
  assign dram_rd_sel_o = sel_q.dram_rd;
  assign dram_wr_sel_o = sel_q.dram_wr;
  assign ram_rw_addr_o = addr_q;

endmodule

// File: tb/tb_ram_rw.sv
// Randomized self-checking bench for ram_rw against a mode/address reference
// model; a narrow address width keeps the wrap-around reachable.
module tb_ram_rw;

  localparam int XLEN = 6;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            dc_i;
  logic            spi_byte_vld_i;
  logic [7:0]      spi_byte_data_i;
  logic            cpu_rst_n_o;
  logic            iram_rd_sel_o, iram_wr_sel_o, dram_rd_sel_o, dram_wr_sel_o;
  logic [XLEN-1:0] ram_rw_addr_o;
  logic [3:0]      ram_wr_byte_en_o;

  ram_rw #(.XLEN(XLEN)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .dc_i             (dc_i),
    .spi_byte_vld_i   (spi_byte_vld_i),
    .spi_byte_data_i  (spi_byte_data_i),
    .cpu_rst_n_o      (cpu_rst_n_o),
    .iram_rd_sel_o    (iram_rd_sel_o),
    .iram_wr_sel_o    (iram_wr_sel_o),
    .dram_rd_sel_o    (dram_rd_sel_o),
    .dram_wr_sel_o    (dram_wr_sel_o),
    .ram_rw_addr_o    (ram_rw_addr_o),
    .ram_wr_byte_en_o (ram_wr_byte_en_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: mode 0 none, 1 IRAM write, 2 IRAM read, 3 DRAM write, 4 DRAM read.
  int m_mode = 0;
  int m_addr = 0;
  bit m_run  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    logic [3:0] exp_sel;
    exp_sel = {m_mode == 2, m_mode == 1, m_mode == 4, m_mode == 3};
    chk({tag, "_rstn"}, cpu_rst_n_o, m_run);
    chk({tag, "_sel"}, {iram_rd_sel_o, iram_wr_sel_o, dram_rd_sel_o, dram_wr_sel_o}, exp_sel);
    chk({tag, "_addr"}, ram_rw_addr_o, m_addr);
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_addr = 0;
    m_run  = 1'b0;
  endtask

  task automatic model_byte(input bit vld, input bit dc, input logic [7:0] d);
    if (!vld) return;
    if (!dc) begin
      m_addr = 0;
      case (d)
        8'h2A: begin m_mode = 0; m_run = 1'b0; end
        8'h2B: begin m_mode = 0; m_run = 1'b1; end
        8'h2C: begin m_mode = 1; m_run = 1'b0; end
        8'h2D: begin m_mode = 2; m_run = 1'b0; end
        8'h2E: begin m_mode = 3; m_run = 1'b0; end
        8'h2F: begin m_mode = 4; m_run = 1'b0; end
        default: m_mode = 0;
      endcase
    end else if (m_mode != 0) begin
      m_addr = (m_addr + 1) % (1 << XLEN);
    end
  endtask

  // One clock cycle: drive at negedge, check the enable before the edge, state after it.
  task automatic step(input bit vld, input bit dc, input logic [7:0] d, input string tag);
    logic [3:0] exp_en;
    @(negedge clk_i);
    spi_byte_vld_i  = vld;
    dc_i            = dc;
    spi_byte_data_i = d;
    #1;
    exp_en = 4'b0000;
    if (vld && dc && (m_mode == 1 || m_mode == 3)) exp_en = 4'b0001 << (m_addr % 4);
    chk({tag, "_en"}, ram_wr_byte_en_o, exp_en);
    @(posedge clk_i);
    #1;
    model_byte(vld, dc, d);
    check_state(tag);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'($urandom), 8'($urandom), tag);
  endtask

  // Reset pulse away from any clock edge, with a data strobe held on the inputs.
  task automatic pulse_reset(input string tag);
    @(negedge clk_i);
    #2;
    spi_byte_vld_i  = 1'b1;
    dc_i            = 1'b1;
    spi_byte_data_i = 8'($urandom);
    rst_i           = 1'b1;
    #1;
    model_reset();
    check_state(tag);
    chk({tag, "_en"}, ram_wr_byte_en_o, 64'h0);
    @(negedge clk_i);
    rst_i          = 1'b0;
    spi_byte_vld_i = 1'b0;
  endtask

  logic [7:0] pat [4];
  logic [7:0] cmd_pool [6];

  initial begin
    pat[0] = 8'hFF; pat[1] = 8'h00; pat[2] = 8'h55; pat[3] = 8'hAA;
    cmd_pool[0] = 8'h2A; cmd_pool[1] = 8'h2B; cmd_pool[2] = 8'h2C;
    cmd_pool[3] = 8'h2D; cmd_pool[4] = 8'h2E; cmd_pool[5] = 8'h2F;

    rst_i = 1'b1;
    spi_byte_vld_i = 1'b0;
    dc_i = 1'b0;
    spi_byte_data_i = 8'h00;
    #1;
    model_reset();
    check_state("reset");
    chk("reset_en", ram_wr_byte_en_o, 64'h0);
    #20;
    @(negedge clk_i);
    rst_i = 1'b0;

    // IRAM write with rotating lanes
    step(1'b1, 1'b0, 8'h2C, "iram_wr_cmd");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, pat[i], "iram_wr_dat");
    chk("iram_wr_final_addr", ram_rw_addr_o, 64'd4);
    chk("iram_wr_hold_reset", cpu_rst_n_o, 64'd0);

    // IRAM read
    step(1'b1, 1'b0, 8'h2D, "iram_rd_cmd");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'h00, "iram_rd_dat");
    chk("iram_rd_final_addr", ram_rw_addr_o, 64'd4);

    // DRAM write, back-to-back with idle gaps interleaved
    step(1'b1, 1'b0, 8'h2E, "dram_wr_cmd");
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, pat[i], "dram_wr_dat");
      if (i == 1) idle("dram_wr_gap");
    end

    // DRAM read
    step(1'b1, 1'b0, 8'h2F, "dram_rd_cmd");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'h00, "dram_rd_dat");
    chk("dram_rd_final_addr", ram_rw_addr_o, 64'd4);

    // Run, then undefined command, then ignored data
    step(1'b1, 1'b0, 8'h2B, "run_cmd");
    chk("run_rstn", cpu_rst_n_o, 64'd1);
    step(1'b1, 1'b0, 8'h12, "undef_cmd");
    chk("undef_rstn", cpu_rst_n_o, 64'd1);
    step(1'b1, 1'b1, 8'h77, "no_mode_dat");

    // Reset mid-DRAM write, then data must be ignored
    step(1'b1, 1'b0, 8'h2E, "abort_cmd");
    step(1'b1, 1'b1, 8'h01, "abort_dat");
    step(1'b1, 1'b1, 8'h02, "abort_dat");
    chk("abort_pre_addr", ram_rw_addr_o, 64'd2);
    pulse_reset("abort_rst");
    step(1'b1, 1'b1, 8'h03, "post_rst_dat");

    // Address wrap in write mode
    step(1'b1, 1'b0, 8'h2C, "wrap_cmd");
    for (int i = 0; i < (1 << XLEN) + 5; i++) step(1'b1, 1'b1, 8'($urandom), "wrap_dat");

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 15) begin
        if ($urandom_range(0, 6) == 6) step(1'b1, 1'b0, 8'($urandom), "rnd_cmd");
        else step(1'b1, 1'b0, cmd_pool[$urandom_range(0, 5)], "rnd_cmd");
      end else if (r < 80) begin
        step(1'b1, 1'b1, 8'($urandom), "rnd_dat");
      end else if (r < 97) begin
        idle("rnd_idle");
      end else begin
        pulse_reset("rnd_rst");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
